// File: rtl/riscv_div_pkg.sv
// Shared types and constants for the divider controller and its shift pre-calculation.
package riscv_div_pkg;

  localparam int C_WIDTH     = 32;
  localparam int C_LOG_WIDTH = 6;

  typedef enum logic [1:0] {
    OP_UDIV = 2'd0,
    OP_DIV  = 2'd1,
    OP_UREM = 2'd2,
    OP_REM  = 2'd3
  } div_opcode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } div_state_e;

endpackage

// File: rtl/riscv_div_shift_calc.sv
// Divisor normalisation: sign, leading-zero count and pre-shift of B for the serial divider.
module riscv_div_shift_calc #(
  parameter int C_WIDTH     = riscv_div_pkg::C_WIDTH,
  parameter int C_LOG_WIDTH = riscv_div_pkg::C_LOG_WIDTH
) (
  input  logic [C_WIDTH-1:0]     OpB_DI,
  input  logic                   Signed_SI,
  output logic                   Sign_SO,
  output logic                   IsZero_SO,
  output logic [C_LOG_WIDTH-1:0] Shift_DO,
  output logic [C_WIDTH-1:0]     OpBShifted_DO
);

  logic [C_WIDTH-1:0]     val;
  logic [C_LOG_WIDTH-1:0] lz;

  assign Sign_SO   = Signed_SI & OpB_DI[C_WIDTH-1];
  assign val       = OpB_DI ^ {C_WIDTH{Sign_SO}};
  assign IsZero_SO = (OpB_DI == '0);

  // Highest set bit wins because it is visited last.
  always_comb begin
    lz = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < C_WIDTH; i++) begin
      if (val[i]) lz = C_LOG_WIDTH'(C_WIDTH - 1 - i);
    end
  end

  always_comb begin
    if (val == '0)     Shift_DO = C_LOG_WIDTH'(C_WIDTH - 1);
    else if (Signed_SI) Shift_DO = lz - C_LOG_WIDTH'(1);
    else               Shift_DO = lz;
  end

  assign OpBShifted_DO = OpB_DI << Shift_DO;

endmodule

// File: rtl/riscv_div_ctrl.sv
// Request/response sequencer around the serial divider: one operation in flight, flushable.
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | one-cycle divider start
//   WAIT  | divider running; Kill is recorded but the divider always finishes
//   DRAIN | unreachable here, decodes to IDLE
//   RESP  | result held until taken downstream or killed
module riscv_div_ctrl #(
  parameter int C_WIDTH     = riscv_div_pkg::C_WIDTH,
  parameter int C_LOG_WIDTH = riscv_div_pkg::C_LOG_WIDTH,
  parameter int C_TAG_WIDTH = 5
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [1:0]             ReqOpCode_SI,
  input  logic [C_TAG_WIDTH-1:0] ReqTag_DI,
  input  logic                   Kill_SI,
  output logic                   RspVld_SO,
  input  logic                   RspRdy_SI,
  output logic [C_WIDTH-1:0]     RspRes_DO,
  output logic [C_TAG_WIDTH-1:0] RspTag_DO,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  input  logic                   DivOutVld_SI,
  output logic                   DivOutRdy_SO,
  input  logic [C_WIDTH-1:0]     DivRes_DI,
  output logic                   Busy_SO
);
  import riscv_div_pkg::*;

  div_state_e state_d, state_q;
  logic kill_d, kill_q;
  logic load, capture;

  logic [C_WIDTH-1:0]     opa_q, opb_q, res_q;
  logic [C_LOG_WIDTH-1:0] shift_q;
  logic                   zero_q, sign_q;
  logic [1:0]             opcode_q;
  logic [C_TAG_WIDTH-1:0] tag_q;

  logic [C_WIDTH-1:0]     calc_opb;
  logic [C_LOG_WIDTH-1:0] calc_shift;
  logic                   calc_zero, calc_sign;

  riscv_div_shift_calc #(
    .C_WIDTH     (C_WIDTH),
    .C_LOG_WIDTH (C_LOG_WIDTH)
  ) i_shift_calc (
    .OpB_DI        (ReqOpB_DI),
    .Signed_SI     (ReqOpCode_SI[0]),
    .Sign_SO       (calc_sign),
    .IsZero_SO     (calc_zero),
    .Shift_DO      (calc_shift),
    .OpBShifted_DO (calc_opb)
  );

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    load         = 1'b0;
    capture      = 1'b0;
    ReqRdy_SO    = 1'b0;
    DivInVld_SO  = 1'b0;
    DivOutRdy_SO = 1'b0;
    RspVld_SO    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ReqRdy_SO = 1'b1;
        kill_d    = 1'b0;
        if (ReqVld_SI) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        DivInVld_SO = 1'b1;
        if (Kill_SI) kill_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Kill_SI) kill_d = 1'b1;
        if (DivOutVld_SI) begin
          DivOutRdy_SO = 1'b1;
          capture      = 1'b1;
          state_d      = (kill_q | Kill_SI) ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        RspVld_SO = 1'b1;
        if (Kill_SI || RspRdy_SI) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= S_IDLE;
      kill_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      shift_q  <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      opcode_q <= '0;
      tag_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (load) begin
        opa_q    <= ReqOpA_DI;
        opb_q    <= calc_opb;
        shift_q  <= calc_shift;
        zero_q   <= calc_zero;
        sign_q   <= calc_sign;
        opcode_q <= ReqOpCode_SI;
        tag_q    <= ReqTag_DI;
      end
      if (capture) res_q <= DivRes_DI;
    end
  end

  assign DivOpA_DO       = opa_q;
  assign DivOpB_DO       = opb_q;
  assign DivOpBShift_DO  = shift_q;
  assign DivOpBIsZero_SO = zero_q;
  assign DivOpBSign_SO   = sign_q;
  assign DivOpCode_SO    = opcode_q;
  assign RspRes_DO       = res_q;
  assign RspTag_DO       = tag_q;
  assign Busy_SO         = (state_q != S_IDLE);

endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Bench for riscv_div_ctrl with a behavioural serial-divider model and RISC-V divide reference.
module tb_riscv_div_ctrl;

  logic        Clk_CI = 1'b0;
  logic        Rst_RBI = 1'b0;
  logic        ReqVld_SI = 1'b0;
  logic        ReqRdy_SO;
  logic [31:0] ReqOpA_DI = '0, ReqOpB_DI = '0;
  logic [1:0]  ReqOpCode_SI = '0;
  logic [4:0]  ReqTag_DI = '0;
  logic        Kill_SI = 1'b0;
  logic        RspVld_SO;
  logic        RspRdy_SI = 1'b0;
  logic [31:0] RspRes_DO;
  logic [4:0]  RspTag_DO;
  logic [31:0] DivOpA_DO, DivOpB_DO;
  logic [5:0]  DivOpBShift_DO;
  logic        DivOpBIsZero_SO, DivOpBSign_SO;
  logic [1:0]  DivOpCode_SO;
  logic        DivInVld_SO;
  logic        DivOutVld_SI;
  logic        DivOutRdy_SO;
  logic [31:0] DivRes_DI;
  logic        Busy_SO;

  int n_chk = 0, n_pass = 0;

  always #5 Clk_CI = ~Clk_CI;

  riscv_div_ctrl dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .ReqVld_SI(ReqVld_SI), .ReqRdy_SO(ReqRdy_SO),
    .ReqOpA_DI(ReqOpA_DI), .ReqOpB_DI(ReqOpB_DI),
    .ReqOpCode_SI(ReqOpCode_SI), .ReqTag_DI(ReqTag_DI),
    .Kill_SI(Kill_SI),
    .RspVld_SO(RspVld_SO), .RspRdy_SI(RspRdy_SI),
    .RspRes_DO(RspRes_DO), .RspTag_DO(RspTag_DO),
    .DivOpA_DO(DivOpA_DO), .DivOpB_DO(DivOpB_DO),
    .DivOpBShift_DO(DivOpBShift_DO),
    .DivOpBIsZero_SO(DivOpBIsZero_SO), .DivOpBSign_SO(DivOpBSign_SO),
    .DivOpCode_SO(DivOpCode_SO),
    .DivInVld_SO(DivInVld_SO), .DivOutVld_SI(DivOutVld_SI),
    .DivOutRdy_SO(DivOutRdy_SO), .DivRes_DI(DivRes_DI),
    .Busy_SO(Busy_SO)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // RISC-V M-extension results, straight from the ISA rules.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd1: ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'd2: ref_div = (b == 0) ? a : a % b;
      default: ref_div = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
    endcase
  endfunction

  function automatic int ref_shift(input logic [31:0] b, input logic [1:0] op);
    logic [31:0] t;
    int lz;
    t  = (op[0] && b[31]) ? ~b : b;
    lz = 0;
    while (lz < 32 && t[31-lz] == 1'b0) lz++;
    if (t == 0) ref_shift = 31;
    else        ref_shift = op[0] ? lz - 1 : lz;
  endfunction

  // Serial divider model: idle it shows a random done level; busy it takes shift+2 cycles
  // including the done cycle, and holds done until released.
  logic [31:0] cur_a, cur_b;
  logic [1:0]  cur_op;
  logic        dv_busy, idle_vld;
  int          dv_cnt;
  logic [31:0] dv_res, junk;

  always @(negedge Clk_CI) begin
    idle_vld <= 1'($urandom);
    junk     <= $urandom;
  end

  always @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      dv_busy <= 1'b0;
      dv_cnt  <= 0;
      dv_res  <= '0;
    end else if (!dv_busy) begin
      if (DivInVld_SO) begin
        dv_busy <= 1'b1;
        dv_cnt  <= int'(DivOpBShift_DO) + 1;
        dv_res  <= ref_div(cur_a, cur_b, cur_op);
      end
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
    end else if (DivOutRdy_SO) begin
      dv_busy <= 1'b0;
    end
  end

  assign DivOutVld_SI = dv_busy ? (dv_cnt == 0) : idle_vld;
  assign DivRes_DI    = (dv_busy && dv_cnt == 0) ? dv_res : junk;

  task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic [4:0] tag);
    @(negedge Clk_CI);
    chk("req_rdy_idle", 32'(ReqRdy_SO), 1);
    cur_a = a; cur_b = b; cur_op = op;
    ReqVld_SI = 1'b1; ReqOpA_DI = a; ReqOpB_DI = b; ReqOpCode_SI = op; ReqTag_DI = tag;
    @(negedge Clk_CI);
    ReqVld_SI = 1'b0; ReqOpA_DI = $urandom; ReqOpB_DI = $urandom;
  endtask

  // kill_at: -1 none, 0 during ISSUE, k>0 k cycles after ISSUE. kill_resp: kill together with ready.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [4:0] tag, input int kill_at, input int stall, input bit kill_resp);
    int sh, lat, dor;
    bit saw_vld, done;
    logic [31:0] exp_res, exp_opb;
    sh      = ref_shift(b, op);
    exp_opb = b << sh;
    exp_res = ref_div(a, b, op);
    start_req(a, b, op, tag);
    chk("issue_vld", 32'(DivInVld_SO), 1);
    chk("issue_opa", DivOpA_DO, a);
    chk("issue_opb", DivOpB_DO, exp_opb);
    chk("issue_shift", 32'(DivOpBShift_DO), 32'(sh));
    chk("issue_zero", 32'(DivOpBIsZero_SO), 32'(b == 0));
    chk("issue_sign", 32'(DivOpBSign_SO), 32'(op[0] & b[31]));
    chk("issue_opcode", 32'(DivOpCode_SO), 32'(op));
    chk("issue_busy", {30'd0, ReqRdy_SO, Busy_SO}, 32'd1);
    chk("issue_no_release", 32'(DivOutRdy_SO), 0);
    Kill_SI = (kill_at == 0);
    lat = 1; dor = 0; saw_vld = 0; done = 0;
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      @(negedge Clk_CI);
      Kill_SI = (kill_at == cyc);
      lat++;
      if (DivInVld_SO) chk("single_issue", 32'(DivInVld_SO), 0);
      if (DivOutVld_SI && DivOutRdy_SO) dor++;
      if (RspVld_SO) saw_vld = 1;
      if (kill_at >= 0) done = !Busy_SO;
      else              done = RspVld_SO;
    end
    Kill_SI = 1'b0;
    if (!done) begin
      chk("timeout", 32'(done), 1);
      return;
    end
    if (kill_at >= 0) begin
      chk("kill_no_rsp", 32'(saw_vld), 0);
      chk("kill_release_pulses", 32'(dor), 1);
      chk("kill_idle", 32'(ReqRdy_SO), 1);
      return;
    end
    chk("latency", 32'(lat), 32'(sh + 4));
    chk("release_pulses", 32'(dor), 1);
    chk("rsp_res", RspRes_DO, exp_res);
    chk("rsp_tag", 32'(RspTag_DO), 32'(tag));
    chk("div_opb_stable", DivOpB_DO, exp_opb);
    repeat (stall) begin
      @(negedge Clk_CI);
      chk("stall_vld", 32'(RspVld_SO), 1);
      chk("stall_res", RspRes_DO, exp_res);
      chk("stall_tag", 32'(RspTag_DO), 32'(tag));
      chk("stall_req_rdy", 32'(ReqRdy_SO), 0);
    end
    RspRdy_SI = 1'b1;
    Kill_SI   = kill_resp;
    @(negedge Clk_CI);
    RspRdy_SI = 1'b0;
    Kill_SI   = 1'b0;
    chk("after_rsp_idle", {30'd0, ReqRdy_SO, RspVld_SO}, 32'd2);
  endtask

  initial begin
    logic [31:0] ra, rb;
    #3;
    chk("rst_req_rdy", 32'(ReqRdy_SO), 1);
    chk("rst_outs", {27'd0, RspVld_SO, DivInVld_SO, DivOutRdy_SO, Busy_SO, DivOpBIsZero_SO}, 0);
    chk("rst_data", DivOpA_DO | DivOpB_DO | RspRes_DO | {27'd0, RspTag_DO} | {26'd0, DivOpBShift_DO}, 0);
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;

    do_op(100, 7, 2'd0, 5'd3, -1, 0, 0);
    do_op(-32'sd7, 2, 2'd3, 5'd9, -1, 1, 0);
    do_op(5, 0, 2'd0, 5'd1, -1, 0, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 5'd30, -1, 0, 0);
    do_op(1000, 3, 2'd0, 5'd7, 3, 0, 0);
    do_op(9, 3, 2'd0, 5'd8, -1, 0, 0);
    do_op(12345, 17, 2'd2, 5'd21, -1, 5, 0);
    do_op(77, 5, 2'd1, 5'd2, 0, 0, 0);
    do_op(77, 5, 2'd1, 5'd2, -1, 2, 1);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 15);
        2: rb = 0;
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(ra, rb, 2'($urandom), 5'($urandom), -1, $urandom_range(0, 3), 0);
    end

    start_req(1000, 3, 2'd0, 5'd4);
    repeat (4) @(negedge Clk_CI);
    Rst_RBI = 1'b0;
    #1;
    chk("midrst_req_rdy", 32'(ReqRdy_SO), 1);
    chk("midrst_outs", {29'd0, RspVld_SO, DivInVld_SO, Busy_SO}, 0);
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    @(negedge Clk_CI);
    chk("postrst_idle", {29'd0, ReqRdy_SO, RspVld_SO, DivInVld_SO}, 32'd4);
    do_op(9, 3, 2'd0, 5'd5, -1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_div_ctrl.md
RISCV_DIV_CTRL -- requirements
Module: riscv_div_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- C_WIDTH, 32, operand width.
- C_LOG_WIDTH, 6, shift-field width.
- C_TAG_WIDTH, 5, destination tag width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, asynchronous, active-low
- ReqVld_SI / ReqRdy_SO  in/out  1  upstream request handshake
- ReqOpA_DI, ReqOpB_DI  in  C_WIDTH  dividend, divisor
- ReqOpCode_SI  in  2  0 udiv, 1 div, 2 urem, 3 rem
- ReqTag_DI  in  C_TAG_WIDTH  destination tag
- Kill_SI  in  1  flush of the in-flight operation
- RspVld_SO / RspRdy_SI  out/in  1  downstream result handshake
- RspRes_DO  out  C_WIDTH  result
- RspTag_DO  out  C_TAG_WIDTH  result tag
- DivOpA_DO, DivOpB_DO  out  C_WIDTH  divider operands; B pre-shifted
- DivOpBShift_DO  out  C_LOG_WIDTH  divider iteration count
- DivOpBIsZero_SO, DivOpBSign_SO  out  1  divider flags
- DivOpCode_SO  out  2  divider opcode
- DivInVld_SO  out  1  divider start
- DivOutVld_SI  in  1  divider done
- DivOutRdy_SO  out  1  divider release
- DivRes_DI  in  C_WIDTH  divider result
- Busy_SO  out  1  high whenever the FSM is not in IDLE

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, WAIT, DRAIN and RESP; ReqRdy_SO SHALL be 1 only in IDLE.
REQ-004 IDLE with ReqVld_SI=1 SHALL register the operands, opcode, tag and the derived fields (REQ-005..008), then go to ISSUE.
REQ-005 Operand sign and derived value: S = ReqOpCode_SI[0] & ReqOpB_DI[31]; T = B XOR {C_WIDTH{S}}; Lz = leading zeros of T, with Lz=32 when T=0.
REQ-006 Shift rule:
- Signed ops: shift = Lz-1.
- Unsigned ops: shift = Lz.
- Either case: shift SHALL be clamped to 31 when T=0.
REQ-007 DivOpB_DO SHALL be B << shift (logical), and DivOpBShift_DO SHALL be shift.
REQ-008 DivOpBIsZero_SO SHALL be (B==0), DivOpBSign_SO SHALL be S, and DivOpA_DO SHALL be A unmodified.
REQ-009 All Div*_DO data outputs SHALL be registered and stable from ISSUE until the return to IDLE.
REQ-010 ISSUE SHALL assert DivInVld_SO=1 for exactly one cycle, then go to WAIT.
REQ-011 DivOutVld_SI SHALL be ignored in IDLE and ISSUE, because the divider raises it while idle.
REQ-012 WAIT with DivOutVld_SI=1 SHALL capture DivRes_DI into the result register and assert DivOutRdy_SO=1 in that same cycle.
- Not killed: next state RESP.
- Killed (Kill_SI=1 now or earlier in the op): next state IDLE, result discarded.
REQ-013 Kill_SI in WAIT SHALL set a sticky kill flag and SHALL NOT abort the divider; the divider handshake SHALL always complete before IDLE.
REQ-014 Kill_SI in ISSUE SHALL still issue, then proceed via WAIT with the kill flag set.
REQ-015 RESP SHALL hold RspVld_SO=1 with RspRes_DO and RspTag_DO stable until RspRdy_SI=1, then go to IDLE.
- Kill_SI=1 in RESP SHALL drop the result and go to IDLE without RspVld_SO being sampled.
- If Kill_SI and RspRdy_SI arrive in the same cycle, kill wins.
REQ-016 DRAIN is entered only if DivOutRdy_SO could not be asserted coincident with done.
- DRAIN SHALL assert DivOutRdy_SO until DivOutVld_SI=0, then go to IDLE.
- In this implementation DRAIN is unreachable; it SHALL decode to IDLE.
REQ-017 Latency, accept to RspVld_SO: 1 (ISSUE) + divider cycles (shift+2) + 1 (WAIT capture).
- No back-to-back issue; one operation in flight.
REQ-018 Kill_SI in IDLE SHALL have no effect, and an undefined state SHALL go to IDLE.

Reset
REQ-019 On Rst_RBI=0 the block SHALL reset asynchronously:
- State IDLE.
- All registers cleared to 0.
- Kill flag cleared.
REQ-020 Output values during reset SHALL be:
- ReqRdy_SO=1.
- All other outputs 0.
REQ-021 Rst_RBI is shared with the divider; a reset mid-operation SHALL leave both blocks idle with no response issued.

Structure
REQ-022 Opcode enum, FSM state enum and C_WIDTH/C_LOG_WIDTH constants SHALL live in shared package riscv_div_pkg.
REQ-023 Leading-zero count and shift computation SHALL be sub-module riscv_div_shift_calc (combinational, C_WIDTH parameter).
REQ-024 The block SHALL connect port-for-port to the serial divider, with no glue logic.

Verification
REQ-025 udiv 100/7, tag 3 -> DivOpBShift_DO=29, DivOpB_DO=0xE0000000, RspRes_DO=14, RspTag_DO=3.
REQ-026 rem -7/2 -> DivOpBSign_SO=0, DivOpBShift_DO=29, RspRes_DO=0xFFFFFFFF (-1).
REQ-027 udiv 5/0 -> DivOpBIsZero_SO=1, shift 31, RspRes_DO=0xFFFFFFFF; div 0x80000000/-1 -> 0x80000000.
REQ-028 Kill_SI pulsed 3 cycles after issue of udiv 1000/3:
- RspVld_SO never asserted.
- DivOutRdy_SO pulsed on done.
- Next request 9/3 is accepted from IDLE and returns 3.
REQ-029 RspRdy_SI held low 5 cycles in RESP -> RspVld_SO, RspRes_DO and RspTag_DO stable for all 5 cycles; ReqRdy_SO=0 throughout.
REQ-030 Rst_RBI asserted during WAIT -> next cycle ReqRdy_SO=1, RspVld_SO=0, DivInVld_SO=0; a new request then completes correctly.
